// File: rtl/pic_pkg.sv
// Shared definitions for the vectored interrupt controller: SPR offsets and FSM states.
package pic_pkg;

  localparam int unsigned PICOFS_MSB = 2;
  localparam int unsigned PICOFS_LSB = 0;

  localparam logic [2:0] PIC_OFS_PICMR  = 3'd0;
  localparam logic [2:0] PIC_OFS_PICSR  = 3'd1;
  localparam logic [2:0] PIC_OFS_PICTR  = 3'd2;
  localparam logic [2:0] PIC_OFS_PICID  = 3'd3;
  localparam logic [2:0] PIC_OFS_PICEOI = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } pic_state_e;

endpackage

// File: rtl/pic_prio_enc.sv
// Combinational priority encoder: index of the lowest set bit plus a valid flag.
module pic_prio_enc #(
  parameter int unsigned NUM_INTS = 32,
  parameter int unsigned ID_W     = 5
) (
  input  logic [NUM_INTS-1:0] vec,
  output logic [ID_W-1:0]     idx,
  output logic                valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan downwards so the lowest set index is the last one written.
    for (int unsigned i = NUM_INTS; i > 0; i--) begin
      if (vec[i-1]) idx = ID_W'(i - 1);
    end
  end

endmodule

// File: rtl/pic_vec.sv
// Vectored interrupt controller on the SPR bus with ack/EOI handshake.
// Define PIC_SYNC_EN to pass pic_int through a 2-flop synchronizer.
module pic_vec
  import pic_pkg::*;
#(
  parameter int unsigned NUM_INTS = 32,
  parameter int unsigned ID_W     = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                spr_cs,
  input  logic                spr_write,
  input  logic [31:0]         spr_addr,
  input  logic [31:0]         spr_dat_i,
  output logic [31:0]         spr_dat_o,
  input  logic [NUM_INTS-1:0] pic_int,
  input  logic                irq_ack,
  output logic                irq2core,
  output logic [ID_W-1:0]     irq_id,
  output logic                pic_wakeup
);

  logic [NUM_INTS-1:0] pic_src;

`ifdef PIC_SYNC_EN
  logic [NUM_INTS-1:0] sync1, sync2;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pic_int;
      sync2 <= sync1;
    end
  end
  assign pic_src = sync2;
`else
  assign pic_src = pic_int;
`endif

  logic [NUM_INTS-1:2] picmr_hi, pictr_hi;
  logic [NUM_INTS-1:0] picsr, int_d, mask, trig, event_v, clr, pend, id_onehot;
  logic [2:0]          ofs;
  logic                wr, wr_mr, wr_sr, wr_tr, wr_eoi;
  logic                pend_id, ack_clr, enc_valid;
  logic [ID_W-1:0]     enc_idx, id_nx;
  pic_state_e          state, state_nx;
  logic                unused;

  assign unused = ^{spr_addr[31:PICOFS_MSB+1], spr_dat_i};

  // Sources 0/1 are hard-wired unmaskable and level-triggered.
  assign mask = {picmr_hi, 2'b11};
  assign trig = {pictr_hi, 2'b00};

  assign ofs    = spr_addr[PICOFS_MSB:PICOFS_LSB];
  assign wr     = spr_cs & spr_write;
  assign wr_mr  = wr && (ofs == PIC_OFS_PICMR);
  assign wr_sr  = wr && (ofs == PIC_OFS_PICSR);
  assign wr_tr  = wr && (ofs == PIC_OFS_PICTR);
  assign wr_eoi = wr && (ofs == PIC_OFS_PICEOI);

  assign event_v    = mask & pic_src & (~trig | ~int_d);
  assign pend       = picsr & mask;
  assign pic_wakeup = |pend;
  assign id_onehot  = {{(NUM_INTS-1){1'b0}}, 1'b1} << irq_id;
  assign pend_id    = |(pend & id_onehot);
  assign clr        = (wr_sr ? spr_dat_i[NUM_INTS-1:0] : '0) | (ack_clr ? id_onehot : '0);
  assign irq2core   = (state == REQ);

  pic_prio_enc #(.NUM_INTS(NUM_INTS), .ID_W(ID_W)) u_enc (
    .vec   (pend),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_nx = state;
    id_nx    = irq_id;
    ack_clr  = 1'b0;
    case (state)
      IDLE: if (enc_valid) begin
        state_nx = REQ;
        id_nx    = enc_idx;
      end
      REQ: if (irq_ack) begin
        state_nx = SERV;
        ack_clr  = |(trig & id_onehot);
      end else if (!pend_id) begin
        state_nx = IDLE;
      end
      SERV: if (wr_eoi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      picmr_hi <= '0;
      pictr_hi <= '0;
      picsr    <= '0;
      int_d    <= '0;
      state    <= IDLE;
      irq_id   <= '0;
    end else begin
      if (wr_mr) picmr_hi <= spr_dat_i[NUM_INTS-1:2];
      if (wr_tr) pictr_hi <= spr_dat_i[NUM_INTS-1:2];
      picsr  <= (picsr & ~clr) | event_v;
      int_d  <= pic_src;
      state  <= state_nx;
      irq_id <= id_nx;
    end
  end

  always_comb begin
    spr_dat_o = '0;
    case (ofs)
      PIC_OFS_PICMR: spr_dat_o[NUM_INTS-1:0] = mask;
      PIC_OFS_PICSR: spr_dat_o[NUM_INTS-1:0] = picsr;
      PIC_OFS_PICTR: spr_dat_o[NUM_INTS-1:0] = trig;
      PIC_OFS_PICID: spr_dat_o[ID_W+1:0]     = {state, irq_id};
      default:       spr_dat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_pic_vec.sv
// Scoreboard bench for pic_vec: directed scenarios plus randomized rounds against a set-based model.
module tb_pic_vec;
  import pic_pkg::*;

`ifdef PIC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        spr_cs, spr_write;
  logic [31:0] spr_addr, spr_dat_i, spr_dat_o;
  logic [31:0] pic_int;
  logic        irq_ack, irq2core, pic_wakeup;
  logic [4:0]  irq_id;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  pic_vec #(.NUM_INTS(32), .ID_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .spr_cs     (spr_cs),
    .spr_write  (spr_write),
    .spr_addr   (spr_addr),
    .spr_dat_i  (spr_dat_i),
    .spr_dat_o  (spr_dat_o),
    .pic_int    (pic_int),
    .irq_ack    (irq_ack),
    .irq2core   (irq2core),
    .irq_id     (irq_id),
    .pic_wakeup (pic_wakeup)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [31:0] data);
    spr_cs = 1'b1; spr_write = 1'b1; spr_addr = 32'(ofs); spr_dat_i = data;
    tick();
    spr_cs = 1'b0; spr_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] ofs, output logic [31:0] data);
    spr_addr = 32'(ofs);
    #1;
    data = spr_dat_o;
  endtask

  task automatic pulse(input logic [31:0] m);
    pic_int = pic_int | m;
    tick();
    pic_int = pic_int & ~m;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (irq2core !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check({name, "_req"}, 32'(irq2core), 32'd1);
  endtask

  // Monitor: every new request must match the next expected vector.
  initial begin
    logic prev;
    int   e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (irq2core === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got id %0d expected no request", irq_id);
        end else begin
          e = exp_q.pop_front();
          check("req_id", 32'(irq_id), 32'(e));
        end
      end
      prev = irq2core;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, mr, tr, pulses, pending;
    reset = 1'b1; spr_cs = 0; spr_write = 0; spr_addr = 0; spr_dat_i = 0;
    pic_int = 0; irq_ack = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // 1: reset state
    rd(PIC_OFS_PICMR, d); check("rst_picmr", d, 32'h3);
    rd(PIC_OFS_PICTR, d); check("rst_pictr", d, 32'h0);
    rd(PIC_OFS_PICSR, d); check("rst_picsr", d, 32'h0);
    rd(PIC_OFS_PICID, d); check("rst_picid", d, 32'h0);
    rd(3'd5, d);          check("rd_ofs5", d, 32'h0);
    check("rst_irq2core", 32'(irq2core), 0);
    check("rst_wakeup", 32'(pic_wakeup), 0);

    // 2: edge source 4, latency, ack clears, EOI without re-request
    wr(PIC_OFS_PICMR, 32'h3C);
    wr(PIC_OFS_PICTR, 32'h13);
    rd(PIC_OFS_PICMR, d); check("picmr_rb", d, 32'h3F);
    rd(PIC_OFS_PICTR, d); check("pictr_rb", d, 32'h10);
    exp_q.push_back(4);
    pic_int[4] = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      if (i == 1) pic_int[4] = 1'b0;
      check("latency", 32'(irq2core), 32'(i == LAT));
    end
    ack();
    rd(PIC_OFS_PICSR, d); check("edge_ack_clr", d, 32'h0);
    rd(PIC_OFS_PICID, d); check("serv_picid", d, 32'h44);
    wr(PIC_OFS_PICEOI, 0);
    repeat (6) tick();
    check("no_rereq", 32'(irq2core), 0);
    rd(PIC_OFS_PICID, d); check("idle_state", 32'(d[6:5]), 0);

    // 3: level source 5 held high
    exp_q.push_back(5);
    pic_int[5] = 1'b1;
    wait_req("lvl");
    ack();
    rd(PIC_OFS_PICSR, d); check("lvl_ack_keeps", d, 32'h20);
    exp_q.push_back(5);
    wr(PIC_OFS_PICEOI, 0);
    wait_req("lvl_again");
    wr(PIC_OFS_PICSR, 32'h20);
    rd(PIC_OFS_PICSR, d); check("w1c_set_wins", d, 32'h20);
    check("w1c_still_req", 32'(irq2core), 1);
    pic_int[5] = 1'b0;
    repeat (LAT) tick();
    wr(PIC_OFS_PICSR, 32'h20);
    check("lvl_drop_hold", 32'(irq2core), 1);
    tick();
    check("lvl_drop_idle", 32'(irq2core), 0);
    rd(PIC_OFS_PICSR, d); check("lvl_cleared", d, 32'h0);

    // 4: simultaneous 3 and 7, source 0 during REQ(3)
    wr(PIC_OFS_PICMR, 32'hBC);
    wr(PIC_OFS_PICTR, 32'h98);
    exp_q.push_back(3);
    pulse(32'h88);
    wait_req("pri3");
    exp_q.push_back(0);
    exp_q.push_back(7);
    pulse(32'h1);
    repeat (LAT) tick();
    check("id_frozen", 32'(irq_id), 3);
    check("frozen_req", 32'(irq2core), 1);
    ack();
    wr(PIC_OFS_PICEOI, 0);
    wait_req("pri0");
    ack();
    wr(PIC_OFS_PICSR, 32'h1);
    wr(PIC_OFS_PICEOI, 0);
    wait_req("pri7");
    ack();
    wr(PIC_OFS_PICEOI, 0);
    tick();
    rd(PIC_OFS_PICSR, d); check("pri_all_clr", d, 32'h0);

    // 5: withdraw in REQ, stray ack, EOI in REQ
    wr(PIC_OFS_PICMR, 32'h7C);
    exp_q.push_back(6);
    pulse(32'h40);
    wait_req("wd");
    wr(PIC_OFS_PICMR, 32'h3C);
    check("mask_hold", 32'(irq2core), 1);
    wr(PIC_OFS_PICSR, 32'h40);
    check("wd_idle", 32'(irq2core), 0);
    rd(PIC_OFS_PICSR, d); check("wd_picsr", d, 32'h0);
    ack();
    rd(PIC_OFS_PICID, d); check("stray_ack", 32'(d[6:5]), 0);
    exp_q.push_back(2);
    pulse(32'h4);
    wait_req("eoi_req");
    wr(PIC_OFS_PICEOI, 0);
    check("eoi_in_req", 32'(irq2core), 1);
    rd(PIC_OFS_PICID, d); check("eoi_in_req_id", d, 32'h22);
    ack();
    wr(PIC_OFS_PICSR, 32'h4);
    wr(PIC_OFS_PICEOI, 0);

    // Randomized rounds: service order is ascending over pulsed & enabled sources
    for (int r = 0; r < 20; r++) begin
      mr = $urandom | 32'h3;
      tr = $urandom & ~32'h3;
      pulses = $urandom & $urandom & $urandom;
      wr(PIC_OFS_PICMR, mr);
      wr(PIC_OFS_PICTR, tr);
      pending = pulses & mr;
      for (int i = 0; i < 32; i++) if (pending[i]) exp_q.push_back(i);
      pulse(pulses);
      repeat (LAT) tick();
      rd(PIC_OFS_PICSR, d); check("rnd_picsr", d, pending);
      check("rnd_wakeup", 32'(pic_wakeup), 32'(pending != 0));
      for (int i = 0; i < 32; i++) begin
        if (pending[i]) begin
          wait_req("rnd");
          ack();
          if (!tr[i]) wr(PIC_OFS_PICSR, 32'h1 << i);
          wr(PIC_OFS_PICEOI, 0);
        end
      end
      tick();
      rd(PIC_OFS_PICSR, d); check("rnd_done", d, 32'h0);
    end

    // 6: asynchronous reset while in SERV
    wr(PIC_OFS_PICMR, 32'h3C);
    wr(PIC_OFS_PICTR, 32'h10);
    exp_q.push_back(4);
    pulse(32'h10);
    wait_req("rst");
    ack();
    pulse(32'h20);
    reset = 1'b1;
    #1;
    check("arst_irq2core", 32'(irq2core), 0);
    check("arst_irq_id", 32'(irq_id), 0);
    check("arst_wakeup", 32'(pic_wakeup), 0);
    rd(PIC_OFS_PICMR, d); check("arst_picmr", d, 32'h3);
    rd(PIC_OFS_PICSR, d); check("arst_picsr", d, 32'h0);
    rd(PIC_OFS_PICID, d); check("arst_picid", d, 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) tick();
    check("post_rst_idle", 32'(irq2core), 0);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
